// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix result byte streamer.
// RESULT_HDR_EN (when defined) prepends a one-byte header to every result.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int WORD_W       = 16;
  localparam int BYTE_W       = 8;
  localparam int CNT_W        = 4;
  localparam int NUM_WORDS    = 4;
  localparam int BYTES_MATRIX = 8;
  localparam int BYTES_DET    = 2;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

`ifdef RESULT_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  // Room for the full matrix payload plus an optional header slot.
  localparam int STREAM_LEN = BYTES_MATRIX + 1;

  // Index of the final byte of a result, counting the header when present.
  function automatic logic [CNT_W-1:0] last_index(input logic matrix_form);
    if (matrix_form)
      last_index = CNT_W'(BYTES_MATRIX + HDR_BYTES - 1);
    else
      last_index = CNT_W'(BYTES_DET + HDR_BYTES - 1);
  endfunction

  function automatic logic [BYTE_W-1:0] hdr_byte(input logic matrix_form);
    hdr_byte = {HDR_NIBBLE, 3'b000, matrix_form};
  endfunction

endpackage

// File: rtl/matrix_result_tx.sv
// Serialises a 2x2 matrix (C11..C22) or a determinant (C11) into a ready/valid
// byte stream, high byte first. Optional header byte under RESULT_HDR_EN.
module matrix_result_tx
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_form,
  input  logic [WORD_W-1:0] C11,
  input  logic [WORD_W-1:0] C12,
  input  logic [WORD_W-1:0] C21,
  input  logic [WORD_W-1:0] C22,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               form_reg;
  logic [WORD_W-1:0]  words_reg [0:NUM_WORDS-1];
  logic               load;
  logic               is_final;
  logic [BYTE_W-1:0]  data_bytes   [0:BYTES_MATRIX-1];
  logic [BYTE_W-1:0]  stream_bytes [0:STREAM_LEN-1];
  logic [BYTE_W-1:0]  sel_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Operands are captured only from IDLE, so a start during a transfer is inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      form_reg <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) words_reg[i] <= '0;
    end else if (load) begin
      form_reg     <= data_form;
      words_reg[0] <= C11;
      words_reg[1] <= C12;
      words_reg[2] <= C21;
      words_reg[3] <= C22;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_split
      assign data_bytes[2*gi]   = words_reg[gi][WORD_W-1:BYTE_W];
      assign data_bytes[2*gi+1] = words_reg[gi][BYTE_W-1:0];
    end

`ifdef RESULT_HDR_EN
    assign stream_bytes[0] = hdr_byte(form_reg);
    for (gi = 0; gi < BYTES_MATRIX; gi++) begin : g_stream_hdr
      assign stream_bytes[gi+1] = data_bytes[gi];
    end
`else
    for (gi = 0; gi < BYTES_MATRIX; gi++) begin : g_stream
      assign stream_bytes[gi] = data_bytes[gi];
    end
    assign stream_bytes[STREAM_LEN-1] = '0;
`endif
  endgenerate

  // Counter-indexed byte mux; determinant mode simply stops after C11.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < STREAM_LEN; i++) begin
      if (cnt_reg == CNT_W'(i)) sel_byte = stream_bytes[i];
    end
  end

  assign is_final = (cnt_reg == last_index(form_reg));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sel_byte;
        out_last  = is_final;
        if (out_ready) begin
          if (is_final) begin
            cnt_next   = '0;
            state_next = FINISH;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      FINISH: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Directed bench for matrix_result_tx; expected streams are built from the
// operand values (header byte included when RESULT_HDR_EN is defined).
module tb_matrix_result_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        data_form;
  logic [15:0] C11, C12, C21, C22;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q [$];

  matrix_result_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_form (data_form),
    .C11       (C11),
    .C12       (C12),
    .C21       (C21),
    .C22       (C22),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic build_expected(input logic form, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
    logic [15:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    exp_q.delete();
`ifdef RESULT_HDR_EN
    exp_q.push_back({4'hA, 3'b000, form});
`endif
    for (int k = 0; k < (form ? 4 : 1); k++) begin
      exp_q.push_back(w[k][15:8]);
      exp_q.push_back(w[k][7:0]);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_data"},  16'(out_data),  16'd0);
    chk({tag, "_last"},  16'(out_last),  16'd0);
    chk({tag, "_busy"},  16'(busy),      16'd0);
    chk({tag, "_done"},  16'(done),      16'd0);
  endtask

  // Sends one result; stall_at/restart_at select a byte index for backpressure
  // or a spurious start pulse (-1 disables).
  task automatic run_result(input logic form, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input int stall_at, input int restart_at);
    build_expected(form, a, b, c, d);
    data_form = form; C11 = a; C12 = b; C21 = c; C22 = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_form = ~form; C11 = ~a; C12 = ~b; C21 = ~c; C22 = ~d;
    chk("latency_valid", 16'(out_valid), 16'd1);
    chk("send_busy", 16'(busy), 16'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("hold_valid", 16'(out_valid), 16'd1);
          chk("hold_data",  16'(out_data),  16'(exp_q[i]));
          chk("hold_last",  16'(out_last),  16'(i == exp_q.size() - 1));
        end
        out_ready = 1'b1;
      end
      if (i == restart_at) begin
        start = 1'b1;
        data_form = ~form;
        C11 = 16'hDEAD; C12 = 16'hBEEF; C21 = 16'h1357; C22 = 16'h2468;
      end
      chk("byte_valid", 16'(out_valid), 16'd1);
      chk("byte_data",  16'(out_data),  16'(exp_q[i]));
      chk("byte_last",  16'(out_last),  16'(i == exp_q.size() - 1));
      chk("byte_done",  16'(done),      16'd0);
      tick();
      start = 1'b0;
    end
    chk("fin_valid", 16'(out_valid), 16'd0);
    chk("fin_last",  16'(out_last),  16'd0);
    chk("fin_done",  16'(done),      16'd1);
    chk("fin_busy",  16'(busy),      16'd1);
    tick();
    chk("post_done", 16'(done), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    $display("result form=%0d bytes=%0d stall_at=%0d restart_at=%0d",
             form, exp_q.size(), stall_at, restart_at);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data_form = 1'b0; out_ready = 1'b1;
    C11 = '0; C12 = '0; C21 = '0; C22 = '0;
    #1;
    idle_checks("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    idle_checks("idle");

    run_result(1'b1, 16'd7, 16'd7, 16'd3, 16'd3, -1, -1);
    run_result(1'b0, 16'd5, 16'h1111, 16'h2222, 16'h3333, -1, -1);
    run_result(1'b0, 16'hFFFB, 16'd0, 16'd0, 16'd0, -1, -1);
    run_result(1'b1, 16'h1234, 16'hABCD, 16'h8001, 16'h00FF, -1, -1);
`ifdef RESULT_HDR_EN
    run_result(1'b1, 16'd7, 16'd7, 16'd3, 16'd3, 3, -1);
`else
    run_result(1'b1, 16'd7, 16'd7, 16'd3, 16'd3, 2, -1);
`endif
    run_result(1'b1, 16'hCAFE, 16'h0102, 16'hF00D, 16'h7FFF, 5, -1);
    run_result(1'b1, 16'd7, 16'd7, 16'd3, 16'd3, -1, 3);
    run_result(1'b0, 16'h8000, 16'd0, 16'd0, 16'd0, -1, 1);

    // Abort mid-result with reset, then send a fresh result.
    data_form = 1'b1; C11 = 16'd7; C12 = 16'd7; C21 = 16'd3; C22 = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    build_expected(1'b1, 16'd7, 16'd7, 16'd3, 16'd3);
    chk("pre_abort_data", 16'(out_data), 16'(exp_q[4]));
    rst_n = 1'b0;
    #1;
    idle_checks("abort");
    tick();
    idle_checks("abort_hold");
    rst_n = 1'b1;
    tick();
    idle_checks("abort_rel");
    run_result(1'b1, 16'hFFFF, 16'h0001, 16'hFF00, 16'h00FF, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/matrix_result_tx.md
MATRIX_RESULT_TX -- requirements
Module: matrix_result_tx

Interface
REQ-001 SHALL have no parameters; the word width is fixed at 16 bits and the byte width at 8 bits.
REQ-002 SHALL have ports, in order:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to send a processor result
- data_form  input  1  1 = 2x2 matrix result, 0 = determinant result
- C11, C12, C21, C22  input  16 each  signed processor outputs
- out_data  output  8  stream byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts the byte
- out_last  output  1  marks the final byte of a result
- busy  output  1  a transfer is in progress
- done  output  1  one-cycle pulse after the final byte transfers

Function
REQ-003 SHALL implement the FSM states IDLE, SEND and FINISH.
REQ-004 IDLE: busy=0, out_valid=0; on start=1, SHALL latch data_form and all four C words and move to SEND.
REQ-005 SHALL assert out_valid with the first byte in the cycle after start is sampled (latency of 1 cycle).
REQ-006 Transfer occurs only on a rising edge where out_valid and out_ready are both 1.
REQ-007 SHALL hold out_data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-008 SHALL present the next byte in the cycle after each transfer, with no bubble.
REQ-009 Byte order SHALL be high byte then low byte of each word.
REQ-010 Matrix mode SHALL send the words in the order C11, C12, C21, C22, for 8 bytes.
REQ-011 Determinant mode SHALL send C11 only, for 2 bytes; C12, C21 and C22 are ignored.
REQ-012 SHALL assert out_last only together with the final byte of a result.
REQ-013 On the transfer of the last byte, SHALL go to FINISH with out_valid=0.
REQ-014 FINISH SHALL last one cycle, with done=1 and busy=1, then return to IDLE.
REQ-015 busy SHALL be 1 in SEND and FINISH.
REQ-016 SHALL ignore start while busy=1, leaving the latched data and progress unchanged.
REQ-017 SHALL pass the C inputs through bit-exact, including two's complement negative values.
REQ-018 SHALL use a 4-bit byte counter; it cannot wrap because the maximum count is 9.

Reset
REQ-019 When rst_n=0, SHALL immediately force: state=IDLE, out_data=8'h00, out_valid=0, out_last=0, busy=0, done=0, byte counter=0, latched words=0.
REQ-020 Reset during SEND SHALL abort the result with no out_last and no done.
REQ-021 After release, SHALL accept the next start normally.

Configuration
REQ-022 Macro RESULT_HDR_EN selects a header byte.
REQ-023 With RESULT_HDR_EN defined, SHALL send a header byte {4'hA, 3'b000, data_form} before the data.
- Byte counts become 9 (matrix) and 3 (determinant).
- out_last placement is unchanged in meaning (final byte of the result).
REQ-024 With RESULT_HDR_EN undefined, SHALL send no header byte.

Structure
REQ-025 Package matrix_pkg SHALL hold:
- the FSM state enum
- the constants BYTES_MATRIX=8, BYTES_DET=2 and HDR_NIBBLE=4'hA
REQ-026 SHALL be a single module with no sub-module; byte selection is a counter-indexed mux inside the module.

Verification
REQ-027 Matrix case: data_form=1, C=(7,7,3,3), out_ready=1.
- Bytes 00 07 00 07 00 03 00 03, with out_last on the 8th byte.
- done one cycle later.
REQ-028 Determinant case: data_form=0, C11=5 -> bytes 00 05, out_last on the 2nd byte.
- C11=-5 -> bytes FF FB.
REQ-029 Backpressure: out_ready low for 3 cycles at byte 3 of a matrix result.
- out_data=00 and out_valid=1 held stable throughout.
- Stream resumes with no lost or duplicated bytes.
REQ-030 start pulsed mid-stream with different C values -> the original 8 bytes are unchanged and only one done pulse occurs.
REQ-031 rst_n low after 4 bytes have transferred -> all outputs are 0 immediately; a new start then sends a full result.
REQ-032 With RESULT_HDR_EN defined: determinant case 5 -> bytes A0 00 05; matrix case -> first byte A1, 9 bytes total.
